// File: rtl/decoder_alu_cache_if.sv
// Datapath bundle between the decode/execute/memory stage and its neighbours.
// ALU_OVF_EN adds the signed-overflow flag to the bundle.
interface decoder_alu_cache_if;
    logic [31:0] instruction;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        reg2loc;
    logic        uncond_branch;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [3:0]  alu_control;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic [31:0] sign_extend;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_data;
    logic        illegal;
`ifdef ALU_OVF_EN
    logic        overflow;

    modport master (
        output instruction, read_data1, read_data2,
        input  reg2loc, uncond_branch, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_control, rn, rm, rt, sign_extend,
               alu_result, zero, mem_data, illegal, overflow
    );
    modport slave (
        input  instruction, read_data1, read_data2,
        output reg2loc, uncond_branch, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_control, rn, rm, rt, sign_extend,
               alu_result, zero, mem_data, illegal, overflow
    );
`else
    modport master (
        output instruction, read_data1, read_data2,
        input  reg2loc, uncond_branch, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_control, rn, rm, rt, sign_extend,
               alu_result, zero, mem_data, illegal
    );
    modport slave (
        input  instruction, read_data1, read_data2,
        output reg2loc, uncond_branch, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_control, rn, rm, rt, sign_extend,
               alu_result, zero, mem_data, illegal
    );
`endif
endinterface

// File: rtl/decoder_alu_cache.sv
// LEGv8-subset decode, ALU and 64x32 data store for the single-cycle core.
// Optional: define ALU_OVF_EN to drive the signed-overflow flag.
module decoder_alu_cache (
    input  logic                 clock,
    input  logic                 reset_n,
    decoder_alu_cache_if.slave   bus
);
    typedef struct packed {
        logic reg2loc;
        logic uncond_branch;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    ctrl_t       dec_ctrl;
    ctrl_t       ctrl;
    logic [3:0]  dec_aluc;
    logic [3:0]  aluc;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic [31:0] ins;
    logic [31:0] op_b;
    logic [31:0] result;
    logic [5:0]  index;
    logic [64*32-1:0] mem_flat;

    assign ins = bus.instruction;

    always_comb begin
        dec_ctrl    = '0;
        dec_aluc    = 4'b0010;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (ins[31:21] == 11'b10001011000) begin
            dec_ctrl.reg_write = 1'b1;
        end else if (ins[31:21] == 11'b11001011000) begin
            dec_ctrl.reg_write = 1'b1;
            dec_aluc           = 4'b0110;
        end else if (ins[31:21] == 11'b10001010000) begin
            dec_ctrl.reg_write = 1'b1;
            dec_aluc           = 4'b0000;
        end else if (ins[31:21] == 11'b10101010000) begin
            dec_ctrl.reg_write = 1'b1;
            dec_aluc           = 4'b0001;
        end else if (ins[31:22] == 10'b1001000100) begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_imm            = {{20{ins[21]}}, ins[21:10]};
        end else if (ins[31:21] == 11'b11111000010) begin
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_imm             = {{23{ins[20]}}, ins[20:12]};
        end else if (ins[31:21] == 11'b11111000000) begin
            dec_ctrl.reg2loc   = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_imm            = {{23{ins[20]}}, ins[20:12]};
        end else if (ins[31:24] == 8'b10110100) begin
            dec_ctrl.reg2loc = 1'b1;
            dec_ctrl.branch  = 1'b1;
            dec_aluc         = 4'b0111;
            dec_imm          = {{13{ins[23]}}, ins[23:5]};
        end else if (ins[31:26] == 6'b000101) begin
            dec_ctrl.uncond_branch = 1'b1;
            dec_imm                = {{6{ins[25]}}, ins[25:0]};
        end else begin
            dec_illegal = 1'b1;
        end
    end

    // Reset masks the control word; the immediate and register fields stay live.
    assign ctrl = reset_n ? dec_ctrl : '0;
    assign aluc = reset_n ? dec_aluc : 4'b0000;

    assign bus.reg2loc       = ctrl.reg2loc;
    assign bus.uncond_branch = ctrl.uncond_branch;
    assign bus.branch        = ctrl.branch;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.alu_src       = ctrl.alu_src;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_control   = aluc;
    assign bus.illegal       = reset_n & dec_illegal;
    assign bus.rn            = ins[9:5];
    assign bus.rm            = ins[20:16];
    assign bus.rt            = ins[4:0];
    assign bus.sign_extend   = dec_imm;

    assign op_b = ctrl.alu_src ? dec_imm : bus.read_data2;

    always_comb begin
        case (aluc)
            4'b0000: result = bus.read_data1 & op_b;
            4'b0001: result = bus.read_data1 | op_b;
            4'b0010: result = bus.read_data1 + op_b;
            4'b0110: result = bus.read_data1 - op_b;
            4'b0111: result = op_b;
            4'b1100: result = ~(bus.read_data1 | op_b);
            default: result = '0;
        endcase
    end

    assign bus.alu_result = result;
    assign bus.zero       = (result == 32'd0);

`ifdef ALU_OVF_EN
    logic ovf;
    always_comb begin
        case (aluc)
            4'b0010: ovf = (bus.read_data1[31] == op_b[31]) && (result[31] != bus.read_data1[31]);
            4'b0110: ovf = (bus.read_data1[31] != op_b[31]) && (result[31] != bus.read_data1[31]);
            default: ovf = 1'b0;
        endcase
    end
    assign bus.overflow = ovf;
`endif

    // Byte address wraps onto 64 words; only bits [7:2] select the word.
    assign index = result[7:2];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg <= '0;
                end else if (ctrl.mem_write && (index == 6'(gi))) begin
                    word_reg <= bus.read_data2;
                end
            end
            assign mem_flat[gi*32 +: 32] = word_reg;
        end
    endgenerate

    assign bus.mem_data = ctrl.mem_read ? mem_flat[{index, 5'b00000} +: 32] : 32'd0;
endmodule

// File: tb/tb_decoder_alu_cache.sv
// Randomized self-checking bench for decoder_alu_cache against a table-driven
// behavioural model of the instruction set and a word-array data store.
module tb_decoder_alu_cache;
    logic clock;
    logic reset_n;
    decoder_alu_cache_if bus();

    decoder_alu_cache dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] pat;
        logic [7:0]  ctrl;   // {reg2loc,uncond,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write}
        logic [3:0]  aluc;
        logic [2:0]  kind;   // immediate field: 0 none, 1 imm12, 2 imm9, 3 imm19, 4 imm26
    } rule_t;

    rule_t       rules [9];
    logic [31:0] ref_mem [64];
    int          errors = 0;
    int          checks = 0;
    int          txn = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, obs, exp, txn);
        end
    endtask

    function automatic logic [31:0] sext(input longint field, input int w);
        longint v;
        v = field;
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return 32'(v);
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  e_ctrl;
        logic [3:0]  e_aluc;
        logic [31:0] e_imm, e_b, e_res, e_mdata;
        logic        e_ill, hit;
        logic [7:0]  o_ctrl;
        longint      s;
        @(negedge clock);
        bus.instruction = ins;
        bus.read_data1  = a;
        bus.read_data2  = b;
        #1;
        txn++;
        hit = 1'b0; e_ctrl = 8'h00; e_aluc = 4'b0010; e_imm = '0;
        for (int i = 0; i < 9; i++) begin
            if (!hit && ((ins & rules[i].mask) == rules[i].pat)) begin
                hit    = 1'b1;
                e_ctrl = rules[i].ctrl;
                e_aluc = rules[i].aluc;
                case (rules[i].kind)
                    3'd1: e_imm = sext(longint'((ins >> 10) & 32'hFFF), 12);
                    3'd2: e_imm = sext(longint'((ins >> 12) & 32'h1FF), 9);
                    3'd3: e_imm = sext(longint'((ins >> 5) & 32'h7FFFF), 19);
                    3'd4: e_imm = sext(longint'(ins & 32'h3FFFFFF), 26);
                    default: e_imm = '0;
                endcase
            end
        end
        e_ill = !hit;
        if (!reset_n) begin
            e_ctrl = 8'h00; e_aluc = 4'b0000; e_ill = 1'b0;
        end
        e_b = e_ctrl[1] ? e_imm : b;
        case (e_aluc)
            4'd0:  e_res = a & e_b;
            4'd1:  e_res = a | e_b;
            4'd2:  e_res = a + e_b;
            4'd6:  e_res = a - e_b;
            4'd7:  e_res = e_b;
            4'd12: e_res = ~(a | e_b);
            default: e_res = '0;
        endcase
        e_mdata = e_ctrl[4] ? ref_mem[(e_res / 4) % 64] : 32'd0;
        o_ctrl = {bus.reg2loc, bus.uncond_branch, bus.branch, bus.mem_read,
                  bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write};
        $display("txn %0d rst_n=%0b ins=%h a=%h b=%h res=%h ctrl=%h", txn, reset_n, ins, a, b, bus.alu_result, o_ctrl);
        check("ctrl",        {24'd0, o_ctrl},           {24'd0, e_ctrl});
        check("alu_control", {28'd0, bus.alu_control},  {28'd0, e_aluc});
        check("illegal",     {31'd0, bus.illegal},      {31'd0, e_ill});
        check("sign_extend", bus.sign_extend,           e_imm);
        check("regs",        {17'd0, bus.rn, bus.rm, bus.rt}, {17'd0, ins[9:5], ins[20:16], ins[4:0]});
        check("alu_result",  bus.alu_result,            e_res);
        check("zero",        {31'd0, bus.zero},         {31'd0, (e_res == 0)});
        check("mem_data",    bus.mem_data,              e_mdata);
`ifdef ALU_OVF_EN
        s = 0;
        if (e_aluc == 4'd2) s = longint'($signed(a)) + longint'($signed(e_b));
        if (e_aluc == 4'd6) s = longint'($signed(a)) - longint'($signed(e_b));
        check("overflow", {31'd0, bus.overflow},
              {31'd0, (s > 64'sd2147483647) || (s < -64'sd2147483648)});
`else
        s = 0;
`endif
        if (reset_n && e_ctrl[2]) ref_mem[(e_res / 4) % 64] = b;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset_n = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (cycles) @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] ldur(input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
        return {11'b11111000010, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] stur(input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
        return {11'b11111000000, imm, 2'b00, rn, rt};
    endfunction

    initial begin
        rules[0] = '{32'hFFE00000, 32'h8B000000, 8'h01, 4'd2, 3'd0};  // ADD
        rules[1] = '{32'hFFE00000, 32'hCB000000, 8'h01, 4'd6, 3'd0};  // SUB
        rules[2] = '{32'hFFE00000, 32'h8A000000, 8'h01, 4'd0, 3'd0};  // AND
        rules[3] = '{32'hFFE00000, 32'hAA000000, 8'h01, 4'd1, 3'd0};  // ORR
        rules[4] = '{32'hFFC00000, 32'h91000000, 8'h03, 4'd2, 3'd1};  // ADDI
        rules[5] = '{32'hFFE00000, 32'hF8400000, 8'h1B, 4'd2, 3'd2};  // LDUR
        rules[6] = '{32'hFFE00000, 32'hF8000000, 8'h86, 4'd2, 3'd2};  // STUR
        rules[7] = '{32'hFF000000, 32'hB4000000, 8'hA0, 4'd7, 3'd3};  // CBZ
        rules[8] = '{32'hFC000000, 32'h14000000, 8'h40, 4'd2, 3'd4};  // B
        clock = 1'b0;
        reset_n = 1'b0;
        bus.instruction = '0;
        bus.read_data1  = '0;
        bus.read_data2  = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed cases from the test plan.
        apply(ldur(9'd0, 5'd2, 5'd1), 32'h40, 32'h0);
        check("plan_ldur_mem_read", {31'd0, bus.mem_read}, 32'd1);
        reset_n = 1'b0;
        apply(ldur(9'd0, 5'd2, 5'd1), 32'h40, 32'h0);
        check("plan_rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        reset_n = 1'b1;
        apply(32'h8B020020, 32'd5, 32'd7);
        check("plan_add", bus.alu_result, 32'd12);
        apply(32'h8B020020, 32'd5, 32'hFFFFFFFB);
        check("plan_add_zero", {31'd0, bus.zero}, 32'd1);
        apply(32'hCB020020, 32'd3, 32'd3);
        apply(32'h8A020020, 32'hF0F0, 32'h0FF0);
        check("plan_and", bus.alu_result, 32'h00F0);
        apply(32'hAA020020, 32'hF0F0, 32'h0FF0);
        check("plan_orr", bus.alu_result, 32'hFFF0);
        apply(stur(9'd8, 5'd1, 5'd3), 32'h100, 32'hDEADBEEF);
        apply(ldur(9'd8, 5'd1, 5'd3), 32'h100, 32'h0);
        check("plan_store_load", bus.mem_data, 32'hDEADBEEF);
        apply(ldur(9'd8, 5'd1, 5'd3), 32'h102, 32'h0);
        check("plan_wrap_load", bus.mem_data, 32'hDEADBEEF);
        apply({8'b10110100, 19'h7FFFF, 5'd4}, 32'h1234, 32'h0);
        check("plan_cbz_imm", bus.sign_extend, 32'hFFFFFFFF);
        apply({6'b000101, 26'd4}, 32'h0, 32'h0);
        check("plan_b_imm", bus.sign_extend, 32'd4);
        apply(32'hFFFFFFFF, 32'h100, 32'h8);
        apply(ldur(9'd8, 5'd1, 5'd3), 32'h100, 32'h0);
        check("plan_illegal_nowrite", bus.mem_data, 32'hDEADBEEF);

        // Store/load pairs to random words with differing ignored address bits.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] base, data;
            base = $urandom;
            data = $urandom;
            apply(stur(9'($urandom), 5'd1, 5'd2), base, data);
            apply(ldur(9'd0, 5'd1, 5'd2), {base[31:8] ^ 24'h5A5A5A, bus.alu_result[7:2], 2'($urandom)}, 32'h0);
        end

        // Random mix of every instruction class plus arbitrary words.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ins, a, b;
            int k;
            k = $urandom_range(0, 9);
            ins = (k < 9) ? (rules[k].pat | ($urandom & ~rules[k].mask)) : $urandom;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = -a;
                default: b = $urandom;
            endcase
            if (i == 120) do_reset(2);
            apply(ins, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
